// File: rtl/mem_stage.sv
// MEM pipeline stage: latches one instruction from EXE, holds the synchronous
// data-SRAM read across WB stalls, extends loads and hands the result to WB.
module mem_stage #(
  parameter int EX_W        = 82,
  parameter int EX_FLAG_BIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ms_allowin,
  input  logic              es2ms_valid,
  input  logic [EX_W+76:0]  es2ms_bus,
  input  logic              ws_allowin,
  output logic              ms2ws_valid,
  output logic [EX_W+69:0]  ms2ws_bus,
  output logic [38:0]       ms_rf_zip,
  input  logic [31:0]       data_sram_rdata,
  output logic              ms_ex,
  input  logic              wb_ex
);

  logic            ms_valid_q, ms_valid_d;
  logic            first_q, first_d;
  logic            buf_valid_q, buf_valid_d;
  logic [31:0]     rdata_buf_q, rdata_buf_d;

  logic            csr_re_q, csr_re_d;
  logic            res_from_mem_q, res_from_mem_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [31:0]     alu_result_q, alu_result_d;
  logic [4:0]      ld_op_q, ld_op_d;
  logic [31:0]     pc_q, pc_d;
  logic [EX_W-1:0] ex_zip_q, ex_zip_d;

  logic            load_en;
  logic [31:0]     raw_rdata;
  logic [1:0]      off;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     load_data;
  logic [31:0]     rf_wdata;
  logic            ws_rf_we;

  assign ms_allowin  = ~ms_valid_q | ws_allowin;
  assign ms2ws_valid = ms_valid_q;
  assign load_en     = es2ms_valid & ms_allowin;

  always_comb begin
    ms_valid_d     = ms_valid_q;
    first_d        = 1'b0;
    buf_valid_d    = buf_valid_q;
    rdata_buf_d    = rdata_buf_q;
    csr_re_d       = csr_re_q;
    res_from_mem_d = res_from_mem_q;
    rf_we_d        = rf_we_q;
    rf_waddr_d     = rf_waddr_q;
    alu_result_d   = alu_result_q;
    ld_op_d        = ld_op_q;
    pc_d           = pc_q;
    ex_zip_d       = ex_zip_q;

    if (wb_ex) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es2ms_valid;
    end

    // Data latch is independent of the flush; a cleared ms_valid discards it.
    if (load_en) begin
      {csr_re_d, res_from_mem_d, rf_we_d, rf_waddr_d, alu_result_d,
       ld_op_d, pc_d, ex_zip_d} = es2ms_bus;
      first_d = ~wb_ex;
    end

    // The SRAM port only shows our data in the first cycle; capture it on a stall.
    if (wb_ex || load_en) begin
      buf_valid_d = 1'b0;
    end else if (ms_valid_q && first_q && !ws_allowin) begin
      buf_valid_d = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q     <= 1'b0;
      first_q        <= 1'b0;
      buf_valid_q    <= 1'b0;
      rdata_buf_q    <= 32'h0;
      csr_re_q       <= 1'b0;
      res_from_mem_q <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= 5'h0;
      alu_result_q   <= 32'h0;
      ld_op_q        <= 5'h0;
      pc_q           <= 32'h0;
      ex_zip_q       <= '0;
    end else begin
      ms_valid_q     <= ms_valid_d;
      first_q        <= first_d;
      buf_valid_q    <= buf_valid_d;
      rdata_buf_q    <= rdata_buf_d;
      csr_re_q       <= csr_re_d;
      res_from_mem_q <= res_from_mem_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      alu_result_q   <= alu_result_d;
      ld_op_q        <= ld_op_d;
      pc_q           <= pc_d;
      ex_zip_q       <= ex_zip_d;
    end
  end

  assign raw_rdata = buf_valid_q ? rdata_buf_q : data_sram_rdata;
  assign off       = alu_result_q[1:0];

  always_comb begin
    ld_byte = raw_rdata[7:0];
    case (off)
      2'd0: ld_byte = raw_rdata[7:0];
      2'd1: ld_byte = raw_rdata[15:8];
      2'd2: ld_byte = raw_rdata[23:16];
      2'd3: ld_byte = raw_rdata[31:24];
      default: ld_byte = raw_rdata[7:0];
    endcase
  end

  assign ld_half = off[1] ? raw_rdata[31:16] : raw_rdata[15:0];

  // ld_op bit order is {b, bu, h, hu, w}.
  always_comb begin
    load_data = 32'h0;
    if (ld_op_q[4]) begin
      load_data = {{24{ld_byte[7]}}, ld_byte};
    end else if (ld_op_q[3]) begin
      load_data = {24'h0, ld_byte};
    end else if (ld_op_q[2]) begin
      load_data = {{16{ld_half[15]}}, ld_half};
    end else if (ld_op_q[1]) begin
      load_data = {16'h0, ld_half};
    end else if (ld_op_q[0]) begin
      load_data = raw_rdata;
    end
  end

  assign rf_wdata  = res_from_mem_q ? load_data : alu_result_q;
  assign ws_rf_we  = rf_we_q & ~ex_zip_q[EX_FLAG_BIT];
  assign ms2ws_bus = {ws_rf_we, rf_waddr_q, rf_wdata, pc_q, ex_zip_q};
  assign ms_rf_zip = {csr_re_q & ms_valid_q, rf_we_q & ms_valid_q, rf_waddr_q, rf_wdata};
  assign ms_ex     = ms_valid_q & ex_zip_q[EX_FLAG_BIT];

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected WB payloads into a
// queue and a negedge monitor pops and compares on every WB handoff.
module tb_mem_stage;

  logic          clk = 1'b0;
  logic          reset;
  logic          ms_allowin;
  logic          es2ms_valid;
  logic [158:0]  es2ms_bus;
  logic          ws_allowin;
  logic          ms2ws_valid;
  logic [151:0]  ms2ws_bus;
  logic [38:0]   ms_rf_zip;
  logic [31:0]   data_sram_rdata;
  logic          ms_ex;
  logic          wb_ex;

  int n_cmp = 0;
  int n_bad = 0;
  logic [151:0] exp_q[$];

  localparam logic [4:0] LD_B = 5'b10000, LD_BU = 5'b01000, LD_H = 5'b00100,
                         LD_HU = 5'b00010, LD_W = 5'b00001, LD_NONE = 5'b00000;

  mem_stage dut (
    .clk(clk), .reset(reset), .ms_allowin(ms_allowin),
    .es2ms_valid(es2ms_valid), .es2ms_bus(es2ms_bus),
    .ws_allowin(ws_allowin), .ms2ws_valid(ms2ws_valid), .ms2ws_bus(ms2ws_bus),
    .ms_rf_zip(ms_rf_zip), .data_sram_rdata(data_sram_rdata),
    .ms_ex(ms_ex), .wb_ex(wb_ex)
  );

  always #5 clk = ~clk;

  function automatic logic [158:0] mk(logic csr, logic rfm, logic we, logic [4:0] wa,
                                      logic [31:0] alu, logic [4:0] ld, logic [31:0] pc,
                                      logic [81:0] ex);
    return {csr, rfm, we, wa, alu, ld, pc, ex};
  endfunction

  function automatic logic [151:0] mk_exp(logic we, logic [4:0] wa, logic [31:0] wd,
                                          logic [31:0] pc, logic [81:0] ex);
    return {we, wa, wd, pc, ex};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction this cycle; optionally expect it to reach WB.
  task automatic issue(input logic [158:0] bus, input logic expect_wb, input logic [31:0] wd);
    es2ms_valid = 1'b1;
    es2ms_bus   = bus;
    if (expect_wb)
      exp_q.push_back(mk_exp(bus[156] & ~bus[2], bus[155:151], wd, bus[113:82], bus[81:0]));
  endtask

  always @(negedge clk) begin
    if (!reset && ms2ws_valid && ws_allowin) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL ms2ws_unexpected: got %h want no handoff", ms2ws_bus);
      end else begin
        logic [151:0] e;
        e = exp_q.pop_front();
        if (ms2ws_bus !== e) begin
          n_bad++;
          $display("FAIL ms2ws_bus: got %h want %h", ms2ws_bus, e);
        end
      end
    end
  end

  initial begin
    logic [81:0] exv;
    reset = 1'b1; es2ms_valid = 1'b0; es2ms_bus = '0; ws_allowin = 1'b1;
    data_sram_rdata = 32'h0; wb_ex = 1'b0;
    tick(); tick();
    chk("rst_ms2ws_valid", {63'h0, ms2ws_valid}, 64'h0);
    chk("rst_ms_ex", {63'h0, ms_ex}, 64'h0);
    chk("rst_rf_zip_ctl", {62'h0, ms_rf_zip[38:37]}, 64'h0);
    chk("rst_ms_allowin", {63'h0, ms_allowin}, 64'h1);
    reset = 1'b0;
    tick();

    // Load word, no stall
    issue(mk(0, 1, 1, 5'd5, 32'h0000_1000, LD_W, 32'h1C00_0000, '0), 1, 32'h8899_AABB);
    tick();
    es2ms_valid = 1'b0; data_sram_rdata = 32'h8899_AABB;
    #1;
    chk("ldw_rf_zip", {25'h0, ms_rf_zip}, {25'h0, 2'b01, 5'd5, 32'h8899_AABB});
    tick();
    data_sram_rdata = 32'h0;
    chk("ldw_one_cycle", {63'h0, ms2ws_valid}, 64'h0);
    tick();

    // Back-to-back byte/half loads, zero bubbles
    data_sram_rdata = 32'h80F1_7F02;
    issue(mk(0, 1, 1, 5'd1, 32'h0000_2003, LD_B,  32'h1C00_0010, '0), 1, 32'hFFFF_FF80); tick();
    issue(mk(0, 1, 1, 5'd2, 32'h0000_2003, LD_BU, 32'h1C00_0014, '0), 1, 32'h0000_0080); tick();
    issue(mk(0, 1, 1, 5'd3, 32'h0000_2002, LD_H,  32'h1C00_0018, '0), 1, 32'hFFFF_80F1); tick();
    issue(mk(0, 1, 1, 5'd4, 32'h0000_2000, LD_HU, 32'h1C00_001C, '0), 1, 32'h0000_7F02); tick();
    issue(mk(0, 1, 1, 5'd6, 32'h0000_2001, LD_B,  32'h1C00_0020, '0), 1, 32'h0000_007F); tick();
    issue(mk(0, 1, 1, 5'd7, 32'h0000_2000, LD_H,  32'h1C00_0024, '0), 1, 32'h0000_7F02); tick();
    issue(mk(0, 1, 1, 5'd8, 32'h0000_2000, LD_BU, 32'h1C00_0028, '0), 1, 32'h0000_0002); tick();
    issue(mk(0, 0, 1, 5'd9, 32'hABCD_0123, LD_NONE, 32'h1C00_002C, '0), 1, 32'hABCD_0123); tick();
    es2ms_valid = 1'b0;
    tick(); tick();

    // Stall hold across three cycles while SRAM output changes
    issue(mk(0, 1, 1, 5'd10, 32'h0000_3000, LD_W, 32'h1C00_0030, '0), 1, 32'h1234_5678);
    tick();
    es2ms_valid = 1'b0; data_sram_rdata = 32'h1234_5678; ws_allowin = 1'b0;
    #1;
    chk("stall_allowin", {63'h0, ms_allowin}, 64'h0);
    tick();
    data_sram_rdata = 32'hDEAD_BEEF;
    tick(); tick();
    chk("stall_hold", {32'h0, ms_rf_zip[31:0]}, {32'h0, 32'h1234_5678});
    ws_allowin = 1'b1;
    tick();
    chk("stall_released", {63'h0, ms2ws_valid}, 64'h0);

    // Flush while held: buffer and valid must clear, new instruction dropped
    issue(mk(0, 1, 1, 5'd11, 32'h0000_4000, LD_W, 32'h1C00_0040, '0), 0, 32'h0);
    tick();
    es2ms_valid = 1'b0; data_sram_rdata = 32'h1111_2222; ws_allowin = 1'b0;
    tick();
    issue(mk(0, 0, 1, 5'd12, 32'h5555_0000, LD_NONE, 32'h1C00_0044, '0), 0, 32'h0);
    wb_ex = 1'b1;
    tick();
    wb_ex = 1'b0; es2ms_valid = 1'b0;
    #1;
    chk("flush_valid", {63'h0, ms2ws_valid}, 64'h0);
    chk("flush_ms_ex", {63'h0, ms_ex}, 64'h0);
    chk("flush_buf_valid", {63'h0, dut.buf_valid_q}, 64'h0);
    ws_allowin = 1'b1;
    tick();

    // Flush with WB accepting: older instruction leaves, incoming one dropped
    issue(mk(0, 0, 1, 5'd3, 32'hCAFE_0000, LD_NONE, 32'h1C00_0050, '0), 1, 32'hCAFE_0000);
    tick();
    issue(mk(0, 0, 1, 5'd4, 32'hBAD0_0000, LD_NONE, 32'h1C00_0054, '0), 0, 32'h0);
    wb_ex = 1'b1;
    tick();
    wb_ex = 1'b0; es2ms_valid = 1'b0;
    #1;
    chk("flush_drop", {63'h0, ms2ws_valid}, 64'h0);
    tick();

    // Exception passes through with rf_we masked
    exv = 82'h3_0000_1234_5678_9ABC_DEF4;
    issue(mk(1, 0, 1, 5'd13, 32'h0000_55AA, LD_NONE, 32'h1C00_0060, exv), 1, 32'h0000_55AA);
    ws_allowin = 1'b0;
    tick();
    es2ms_valid = 1'b0;
    #1;
    chk("exc_ms_ex", {63'h0, ms_ex}, 64'h1);
    chk("exc_rf_zip_ctl", {62'h0, ms_rf_zip[38:37]}, 64'h3);
    ws_allowin = 1'b1;
    tick();
    chk("exc_ms_ex_clear", {63'h0, ms_ex}, 64'h0);

    // Reset during a held load
    issue(mk(0, 1, 1, 5'd14, 32'h0000_6000, LD_W, 32'h1C00_0070, '0), 0, 32'h0);
    tick();
    es2ms_valid = 1'b0; data_sram_rdata = 32'h7777_8888; ws_allowin = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_stall_valid", {63'h0, ms2ws_valid}, 64'h0);
    chk("rst_stall_allowin", {63'h0, ms_allowin}, 64'h1);
    chk("rst_stall_rf_zip", {62'h0, ms_rf_zip[38:37]}, 64'h0);
    ws_allowin = 1'b1;
    tick(); tick();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
